conv_relu_pool: RTL and testbench

- Streaming post-processing stage between the single-filter convolution datapath's result output (result / result_en) and the convolution write bridge.
- Applies optional ReLU, then 2x2 stride-2 max pooling to one feature map arriving in raster order.
- Emits one pooled word per completed 2x2 window, so the write bridge sees a quarter of the convolution result rate.
- Holds one half-row line buffer; no bus interface.

---
 rtl/conv_relu_pool_if.sv | 26 ++
 rtl/conv_relu_pool.sv | 71 +++++++
 tb/tb_conv_relu_pool.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_relu_pool_if.sv
// Stream bundle between the convolution result port and the pooling stage.
// Carries frame control, the input word stream and the pooled output stream.
interface conv_relu_pool_if #(
    parameter int width = 32,
    parameter int cnt_w = 6
);
    logic             frame_start;
    logic             relu_en;
    logic [width-1:0] in_data;
    logic             in_en;
    logic [width-1:0] out_data;
    logic             out_en;
    logic [cnt_w-1:0] out_row;
    logic [cnt_w-1:0] out_col;
    logic             frame_done;

    modport master (
        output frame_start, relu_en, in_data, in_en,
        input  out_data, out_en, out_row, out_col, frame_done
    );

    modport slave (
        input  frame_start, relu_en, in_data, in_en,
        output out_data, out_en, out_row, out_col, frame_done
    );
endinterface

// File: rtl/conv_relu_pool.sv
// Optional ReLU followed by 2x2 stride-2 max pooling on a raster-order map.
// Even rows fold pixel pairs into a half-row line buffer; odd rows emit.
module conv_relu_pool #(
    parameter int width    = 32,
    parameter int map_size = 62,
    parameter int cnt_w    = 6
) (
    input logic             clk,
    input logic             rst_n,
    conv_relu_pool_if.slave bus
);
    localparam int half  = map_size / 2;
    localparam int idx_w = (half > 1) ? $clog2(half) : 1;
    localparam logic [cnt_w-1:0] last = cnt_w'(map_size - 1);

    logic [cnt_w-1:0]        col, row, cur_col, cur_row;
    logic [idx_w-1:0]        idx;
    logic                    col_last, row_last;
    logic signed [width-1:0] pair, v, top, m_pv, m_all;
    logic signed [width-1:0] linebuf [half];

    // frame_start makes the current word pixel (0,0) of the new map
    always_comb begin
        cur_col  = bus.frame_start ? '0 : col;
        cur_row  = bus.frame_start ? '0 : row;
        col_last = (cur_col == last);
        row_last = (cur_row == last);
        idx      = idx_w'(cur_col >> 1);
        v        = (bus.relu_en && bus.in_data[width-1]) ? '0 : bus.in_data;
        top      = linebuf[idx];
        m_pv     = (v > pair) ? v : pair;
        m_all    = (top > m_pv) ? top : m_pv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col            <= '0;
            row            <= '0;
            pair           <= '0;
            bus.out_data   <= '0;
            bus.out_en     <= 1'b0;
            bus.out_row    <= '0;
            bus.out_col    <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.out_en     <= 1'b0;
            bus.frame_done <= 1'b0;
            col            <= cur_col;
            row            <= cur_row;
            if (bus.frame_start) pair <= '0;
            if (bus.in_en) begin
                col <= col_last ? '0 : cur_col + 1'b1;
                if (col_last) row <= row_last ? '0 : cur_row + 1'b1;
                if (!cur_col[0]) begin
                    pair <= v;
                end else if (cur_row[0]) begin
                    bus.out_data   <= m_all;
                    bus.out_row    <= cur_row >> 1;
                    bus.out_col    <= cur_col >> 1;
                    bus.out_en     <= 1'b1;
                    bus.frame_done <= row_last && col_last;
                end
            end
        end
    end

    // top-row pair maxima, consumed by the matching odd-row window
    always_ff @(posedge clk) begin
        if (bus.in_en && cur_col[0] && !cur_row[0]) linebuf[idx] <= m_pv;
    end
endmodule

// File: tb/tb_conv_relu_pool.sv
// Bench for conv_relu_pool: 4x4, 2x2 and 62x62 instances with a scoreboard.
// Model keeps the whole map and takes the max of each 2x2 window directly.
`timescale 1ns/1ps
module tb_conv_relu_pool;
    typedef struct {
        logic [31:0] data;
        int          row;
        int          col;
        bit          done;
        int          stamp;
    } exp_t;

    typedef struct {
        bit               relu;
        logic [3:0][31:0] px;
        logic [31:0]      want;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_relu_pool_if #(.width(32), .cnt_w(6)) b4 ();
    conv_relu_pool_if #(.width(32), .cnt_w(6)) b2 ();
    conv_relu_pool_if #(.width(32), .cnt_w(6)) b62 ();

    conv_relu_pool #(.width(32), .map_size(4), .cnt_w(6)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4));
    conv_relu_pool #(.width(32), .map_size(2), .cnt_w(6)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2));
    conv_relu_pool #(.width(32), .map_size(62), .cnt_w(6)) u62 (
        .clk(clk), .rst_n(rst_n), .bus(b62));

    int tests = 0;
    int fails = 0;
    int ocnt [3];
    int dcnt [3];
    exp_t q0[$], q1[$], q2[$];
    logic [31:0] img [3][64][64];
    int mr [3];
    int mc [3];
    int msz [3] = '{4, 2, 62};
    bit relu_m [3];

    task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic mon(int s, string nm, logic [31:0] d, int r, int c,
                       bit dn);
        exp_t e;
        bit   have;
        have = 1'b0;
        ocnt[s]++;
        if (dn) dcnt[s]++;
        case (s)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            chk({nm, " unexpected out_en"}, 1, 0);
        end else begin
            chk({nm, " data"}, d, e.data);
            chk({nm, " row"}, r, e.row);
            chk({nm, " col"}, c, e.col);
            chk({nm, " done"}, dn, e.done);
            chk({nm, " latency"}, cyc, e.stamp);
        end
    endtask

    always @(negedge clk) begin
        if (b4.out_en === 1'b1)
            mon(0, "m4", b4.out_data, b4.out_row, b4.out_col, b4.frame_done);
        else if (b4.frame_done !== 1'b0) chk("m4 stray done", 1, 0);
        if (b2.out_en === 1'b1)
            mon(1, "m2", b2.out_data, b2.out_row, b2.out_col, b2.frame_done);
        else if (b2.frame_done !== 1'b0) chk("m2 stray done", 1, 0);
        if (b62.out_en === 1'b1)
            mon(2, "m62", b62.out_data, b62.out_row, b62.out_col,
                b62.frame_done);
        else if (b62.frame_done !== 1'b0) chk("m62 stray done", 1, 0);
    end

    function automatic logic [31:0] smax(logic [31:0] a, logic [31:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    task automatic push(int s, exp_t e);
        case (s)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(int s, logic [31:0] d, bit fs);
        case (s)
            0: begin b4.in_data = d; b4.in_en = 1'b1; b4.frame_start = fs; end
            1: begin b2.in_data = d; b2.in_en = 1'b1; b2.frame_start = fs; end
            default: begin
                b62.in_data = d; b62.in_en = 1'b1; b62.frame_start = fs;
            end
        endcase
        @(posedge clk);
        #1;
        b4.in_en = 1'b0;  b4.frame_start = 1'b0;
        b2.in_en = 1'b0;  b2.frame_start = 1'b0;
        b62.in_en = 1'b0; b62.frame_start = 1'b0;
    endtask

    task automatic feed(int s, logic [31:0] d, bit fs);
        logic [31:0] v, m;
        int r, c;
        exp_t e;
        if (fs) begin mr[s] = 0; mc[s] = 0; end
        r = mr[s];
        c = mc[s];
        v = (relu_m[s] && d[31]) ? 32'd0 : d;
        img[s][r][c] = v;
        if (r[0] && c[0]) begin
            m = smax(smax(img[s][r-1][c-1], img[s][r-1][c]),
                     smax(img[s][r][c-1], v));
            e.data  = m;
            e.row   = r / 2;
            e.col   = c / 2;
            e.done  = (r == msz[s] - 1) && (c == msz[s] - 1);
            e.stamp = cyc + 1;
            push(s, e);
        end
        c++;
        if (c == msz[s]) begin
            c = 0;
            r++;
            if (r == msz[s]) r = 0;
        end
        mr[s] = r;
        mc[s] = c;
        drive(s, d, fs);
    endtask

    initial begin
        vec_t vt [5];
        exp_t e;
        int d0;
        vt[0] = '{1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                        32'hFFFF_FFFD}, 32'h0};
        vt[1] = '{1'b0, {32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                        32'hFFFF_FFFD}, 32'hFFFF_FFFF};
        vt[2] = '{1'b0, {32'hFFFF_FFFF, 32'h1, 32'h8000_0000,
                        32'h7FFF_FFFF}, 32'h7FFF_FFFF};
        vt[3] = '{1'b1, {32'd2, 32'd3, 32'hFFFF_FFF7, 32'd5}, 32'd5};
        vt[4] = '{1'b0, {32'hFFFF_FFF8, 32'hFFFF_FFF9, 32'hFFFF_FFFA,
                        32'hFFFF_FFFB}, 32'hFFFF_FFFB};

        rst_n = 1'b0;
        b4.frame_start = 0;  b4.in_en = 0;  b4.in_data = 0;  b4.relu_en = 1;
        b2.frame_start = 0;  b2.in_en = 0;  b2.in_data = 0;  b2.relu_en = 0;
        b62.frame_start = 0; b62.in_en = 0; b62.in_data = 0; b62.relu_en = 0;
        relu_m[0] = 1'b1;
        relu_m[1] = 1'b0;
        relu_m[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_data", b4.out_data, 0);
        chk("rst out_en", b4.out_en, 0);
        chk("rst out_row", b4.out_row, 0);
        chk("rst out_col", b4.out_col, 0);
        chk("rst frame_done", b4.frame_done, 0);
        chk("rst out_data 62", b62.out_data, 0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 16; i++) feed(0, i, 1'b0);
        idle(3);
        chk("ramp out count", ocnt[0], 4);
        chk("ramp done count", dcnt[0], 1);
        chk("ramp last value", b4.out_data, 15);

        for (int k = 0; k < 5; k++) begin
            b2.relu_en = vt[k].relu;
            for (int j = 0; j < 3; j++) drive(1, vt[k].px[j], 1'b0);
            e.data  = vt[k].want;
            e.row   = 0;
            e.col   = 0;
            e.done  = 1'b1;
            e.stamp = cyc + 1;
            push(1, e);
            drive(1, vt[k].px[3], 1'b0);
            idle(1);
        end
        idle(2);
        chk("table out count", ocnt[1], 5);

        d0 = dcnt[0];
        for (int i = 0; i < 6; i++) feed(0, i, 1'b0);
        feed(0, 100, 1'b1);
        for (int k = 1; k < 16; k++) feed(0, 10 * k - 60, 1'b0);
        idle(3);
        chk("restart done count", dcnt[0] - d0, 1);
        chk("restart out count", ocnt[0], 9);

        d0 = dcnt[0];
        for (int i = 0; i < 10; i++) feed(0, i, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_data", b4.out_data, 0);
        chk("async out_row", b4.out_row, 0);
        chk("async out_col", b4.out_col, 0);
        chk("async col", u4.col, 0);
        idle(2);
        rst_n = 1'b1;
        mr[0] = 0;
        mc[0] = 0;
        idle(1);
        for (int i = 0; i < 16; i++) feed(0, i, 1'b0);
        idle(3);
        chk("post-reset done count", dcnt[0] - d0, 1);
        chk("post-reset last value", b4.out_data, 15);

        for (int i = 0; i < 62 * 62; i++) begin
            while ($urandom_range(99) >= 30) idle(1);
            feed(2, $urandom, 1'b0);
        end
        idle(3);
        chk("gapped out count", ocnt[2], 961);
        chk("gapped done count", dcnt[2], 1);
        chk("gapped end col", u62.col, 0);
        chk("gapped end row", u62.row, 0);

        chk("q4 drained", q0.size(), 0);
        chk("q2 drained", q1.size(), 0);
        chk("q62 drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
